// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 3x3 convolution scheduler.
package conv_pkg;
  localparam int DW       = 8;
  localparam int CONV_LAT = 2;
  localparam int NWGT     = 9;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_e;
endpackage

// File: rtl/conv_line_buf.sv
// One image row of delay: read-before-write at the same column address.
module conv_line_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 28,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);
  logic [DW-1:0] r_mem [DEPTH];

  // Combinational read returns the previous row's pixel before it is overwritten.
  assign o_dout = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_din;
  end
endmodule

// File: rtl/conv_sched.sv
// 3x3 convolution window/weight scheduler with line buffers and valid pipe.
// Optional result counter port enabled by defining CONV_SCHED_STATUS_CNT_EN.
module conv_sched
  import conv_pkg::*;
#(
  parameter int DW    = conv_pkg::DW,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            w_valid,
  input  logic [DW-1:0]   w_data,
  input  logic            pix_valid,
  input  logic [DW-1:0]   pix_data,
  output logic            pix_ready,
  output logic [3*DW-1:0] data_im_a,
  output logic [3*DW-1:0] data_im_b,
  output logic [3*DW-1:0] data_im_c,
  output logic [3*DW-1:0] data_fi_a,
  output logic [3*DW-1:0] data_fi_b,
  output logic [3*DW-1:0] data_fi_c,
  output logic            out_valid,
  output logic            busy,
`ifdef CONV_SCHED_STATUS_CNT_EN
  output logic [15:0]     result_cnt,
`endif
  output logic            done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_e            r_state, w_state_nxt;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [3:0]        r_widx;
  logic [1:0]        r_fcnt;
  logic              r_w_loaded;
  logic [DW-1:0]     r_wgt [NWGT];
  logic [3*DW-1:0]   r_win_a, r_win_b, r_win_c;
  logic [CONV_LAT:0] r_vld_pipe;

  logic          w_accept, w_col_end, w_last_pix, w_win_vld;
  logic          w_start_go, w_load_go, w_wgt_we;
  logic [3:0]    w_wgt_idx;
  logic [DW-1:0] w_lb1_q, w_lb2_q;

  assign w_accept   = pix_valid && (r_state == RUN);
  assign w_col_end  = (r_col == CW'(IMG_W - 1));
  assign w_last_pix = w_col_end && (r_row == RW'(IMG_H - 1));
  assign w_win_vld  = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));

  always_comb begin
    w_state_nxt = r_state;
    w_start_go  = 1'b0;
    w_load_go   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A weight beat wins over a simultaneous start.
        if (w_valid) begin
          w_load_go   = 1'b1;
          w_state_nxt = LOAD;
        end else if (start && r_w_loaded) begin
          w_start_go  = 1'b1;
          w_state_nxt = RUN;
        end
      end
      LOAD:    if (w_valid && (r_widx == 4'(NWGT - 1))) w_state_nxt = IDLE;
      RUN:     if (w_accept && w_last_pix) w_state_nxt = FLUSH;
      FLUSH:   if (r_fcnt == 2'(CONV_LAT)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_wgt_we  = w_load_go || ((r_state == LOAD) && w_valid);
  assign w_wgt_idx = w_load_go ? 4'd0 : r_widx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_widx     <= '0;
      r_w_loaded <= 1'b0;
      r_fcnt     <= '0;
      for (int i = 0; i < NWGT; i++) r_wgt[i] <= '0;
    end else begin
      if (w_wgt_we) begin
        r_wgt[w_wgt_idx] <= w_data;
        r_widx           <= w_wgt_idx + 4'd1;
      end
      if ((r_state == LOAD) && w_valid && (r_widx == 4'(NWGT - 1))) r_w_loaded <= 1'b1;
      r_fcnt <= (r_state == FLUSH) ? r_fcnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start_go) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // lb1 holds row r-1; lb2 is fed from lb1's old value so it holds row r-2.
  conv_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
    .clk    (clk),
    .i_we   (w_accept),
    .i_addr (r_col),
    .i_din  (pix_data),
    .o_dout (w_lb1_q)
  );

  conv_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb2 (
    .clk    (clk),
    .i_we   (w_accept),
    .i_addr (r_col),
    .i_din  (w_lb1_q),
    .o_dout (w_lb2_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_a <= '0;
      r_win_b <= '0;
      r_win_c <= '0;
    end else if (w_accept) begin
      r_win_a <= {r_win_a[2*DW-1:0], w_lb2_q};
      r_win_b <= {r_win_b[2*DW-1:0], w_lb1_q};
      r_win_c <= {r_win_c[2*DW-1:0], pix_data};
    end
  end

  // Free-running so the downstream datapath (no enable) stays aligned across gaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_vld_pipe <= '0;
    else        r_vld_pipe <= {r_vld_pipe[CONV_LAT-1:0], w_win_vld};
  end

`ifdef CONV_SCHED_STATUS_CNT_EN
  logic [15:0] r_result_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     r_result_cnt <= '0;
    else if (w_start_go)                            r_result_cnt <= '0;
    else if (out_valid && (r_result_cnt != 16'hFFFF)) r_result_cnt <= r_result_cnt + 16'd1;
  end

  assign result_cnt = r_result_cnt;
`endif

  assign data_im_a = r_win_a;
  assign data_im_b = r_win_b;
  assign data_im_c = r_win_c;
  assign data_fi_a = {r_wgt[0], r_wgt[1], r_wgt[2]};
  assign data_fi_b = {r_wgt[3], r_wgt[4], r_wgt[5]};
  assign data_fi_c = {r_wgt[6], r_wgt[7], r_wgt[8]};
  assign out_valid = r_vld_pipe[CONV_LAT];
  assign pix_ready = (r_state == RUN);
  assign busy      = (r_state == RUN) || (r_state == FLUSH);
  assign done      = (r_state == FLUSH) && (r_fcnt == 2'(CONV_LAT));
endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched with a frame-level reference model and literal anchors.
module tb_conv_sched;
  localparam int DW   = 8;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            w_valid = 1'b0;
  logic [DW-1:0]   w_data = '0;
  logic            pix_valid = 1'b0;
  logic [DW-1:0]   pix_data = '0;
  logic            pix_ready, out_valid, busy, done;
  logic [3*DW-1:0] data_im_a, data_im_b, data_im_c;
  logic [3*DW-1:0] data_fi_a, data_fi_b, data_fi_c;
`ifdef CONV_SCHED_STATUS_CNT_EN
  logic [15:0]     result_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  conv_sched #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .data_im_a (data_im_a),
    .data_im_b (data_im_b),
    .data_im_c (data_im_c),
    .data_fi_a (data_fi_a),
    .data_fi_b (data_fi_b),
    .data_fi_c (data_fi_c),
    .out_valid (out_valid),
    .busy      (busy),
`ifdef CONV_SCHED_STATUS_CNT_EN
    .result_cnt(result_cnt),
`endif
    .done      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  int            m_mode;        // 0 idle, 1 loading, 2 streaming, 3 draining
  logic [DW-1:0] m_w [9];
  int            m_wcnt, m_npix, m_fl, m_done_cyc, m_last;
  bit            m_loaded, m_win_ok, m_win_zero;
  logic [DW-1:0] img [NPIX];
  int            due[$];
  int            frame_ov, first_ov_cyc, last_ov_cyc, dut_done_cyc;
  int            acc22;
  logic [15:0]   m_rcnt;

  function automatic logic [3*DW-1:0] row3(input int p);
    return {img[p-2], img[p-1], img[p]};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        m_mode = 0; m_wcnt = 0; m_npix = 0; m_fl = 0; m_done_cyc = -1; m_last = 0;
        m_loaded = 0; m_win_ok = 0; m_win_zero = 1; m_rcnt = '0;
        for (int i = 0; i < 9; i++) m_w[i] = '0;
        due.delete();
        chk("rst_im_a", 32'(data_im_a), 32'(0));
        chk("rst_im_b", 32'(data_im_b), 32'(0));
        chk("rst_im_c", 32'(data_im_c), 32'(0));
        chk("rst_fi", 32'(data_fi_a | data_fi_b | data_fi_c), 32'(0));
        chk("rst_ctl", 32'({out_valid, pix_ready, busy, done}), 32'(0));
      end else begin
        bit exp_ov;
        exp_ov = (due.size() > 0) && (due[0] == cyc);
        if (exp_ov) void'(due.pop_front());
        if (exp_ov && m_rcnt != 16'hFFFF) m_rcnt++;
        chk("fi_a", 32'(data_fi_a), 32'({m_w[0], m_w[1], m_w[2]}));
        chk("fi_b", 32'(data_fi_b), 32'({m_w[3], m_w[4], m_w[5]}));
        chk("fi_c", 32'(data_fi_c), 32'({m_w[6], m_w[7], m_w[8]}));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("done", 32'(done), 32'(cyc == m_done_cyc));
        chk("pix_ready", 32'(pix_ready), 32'(m_mode == 2));
        chk("busy", 32'(busy), 32'(m_mode >= 2));
`ifdef CONV_SCHED_STATUS_CNT_EN
        chk("result_cnt", 32'(result_cnt), 32'(m_rcnt));
`endif
        if (m_win_zero) begin
          chk("win_zero", 32'(data_im_a | data_im_b | data_im_c), 32'(0));
        end else if (m_win_ok) begin
          chk("win_a", 32'(data_im_a), 32'(row3(m_last - 2*W)));
          chk("win_b", 32'(data_im_b), 32'(row3(m_last - W)));
          chk("win_c", 32'(data_im_c), 32'(row3(m_last)));
        end
        if (out_valid) begin
          frame_ov++;
          if (first_ov_cyc < 0) first_ov_cyc = cyc;
          last_ov_cyc = cyc;
        end
        if (done) dut_done_cyc = cyc;

        // advance the model by the inputs the next rising edge will sample
        case (m_mode)
          0: begin
            if (w_valid) begin
              m_w[0] = w_data; m_wcnt = 1; m_mode = 1;
            end else if (start && m_loaded) begin
              m_mode = 2; m_npix = 0; m_win_ok = 0; m_rcnt = '0;
              frame_ov = 0; first_ov_cyc = -1; last_ov_cyc = -1; dut_done_cyc = -2;
            end
          end
          1: begin
            if (w_valid) begin
              m_w[m_wcnt] = w_data;
              m_wcnt++;
              if (m_wcnt == 9) begin m_mode = 0; m_loaded = 1; end
            end
          end
          2: begin
            if (pix_valid) begin
              int r, c;
              r = m_npix / W;
              c = m_npix % W;
              img[m_npix] = pix_data;
              m_last      = m_npix;
              m_win_zero  = 0;
              m_win_ok    = (r >= 2) && (c >= 2);
              if (m_win_ok) due.push_back(cyc + 3);
              m_npix++;
              if (m_npix == NPIX) begin m_mode = 3; m_fl = 0; m_done_cyc = cyc + 3; end
            end
          end
          default: begin
            if (m_fl == 2) m_mode = 0;
            else           m_fl++;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input logic [DW-1:0] ws [9], input bit with_start, input int gap_pct);
    for (int i = 0; i < 9; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        w_valid = 1'b0;
        tick();
      end
      w_valid = 1'b1;
      w_data  = ws[i];
      if (i == 0) start = with_start;
      tick();
      start = 1'b0;
      if (i == 0 && with_start) chk("start_wv_load", 32'(busy), 32'(0));
    end
    w_valid = 1'b0;
  endtask

  // mode 0: row*16+col continuous, 1: same data with valid toggling, 2: random data and gaps
  task automatic run_frame(input int mode, input int max_pix, input bit noise, input bit lit);
    int idx   = 0;
    int guard = 0;
    bit tog   = 1'b1;
    bit pv, acc;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (lit) begin
      chk("lit_fi_a", 32'(data_fi_a), 32'h010203);
      chk("lit_fi_b", 32'(data_fi_b), 32'h040506);
      chk("lit_fi_c", 32'(data_fi_c), 32'h070809);
    end
    while (idx < max_pix && guard < 2000) begin
      pv = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(99) < 65);
      tog = !tog;
      pix_valid = pv;
      pix_data  = (mode == 2) ? DW'($urandom) : DW'((idx / W) * 16 + (idx % W));
      if (noise && pix_ready) begin
        w_valid = $urandom_range(1);
        w_data  = DW'($urandom);
        start   = ($urandom_range(3) == 0);
      end
      acc = pv && pix_ready;
      tick();
      guard++;
      w_valid = 1'b0;
      start   = 1'b0;
      if (acc) begin
        if (mode != 2 && idx == 2*W + 2) begin
          acc22 = cyc;
          chk("lit_win_a", 32'(data_im_a), 32'h000102);
          chk("lit_win_b", 32'(data_im_b), 32'h101112);
          chk("lit_win_c", 32'(data_im_c), 32'h202122);
        end
        idx++;
      end
    end
    pix_valid = 1'b0;
    chk("frame_timeout", 32'(guard < 2000), 32'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic pattern_literals();
    chk("lit_ov_count", 32'(frame_ov), 32'(9));
    chk("lit_ov_lat", 32'(first_ov_cyc - acc22), 32'(3));
    chk("lit_done_last", 32'(dut_done_cyc), 32'(last_ov_cyc));
    chk("lit_busy_after", 32'(busy), 32'(0));
  endtask

  initial begin
    logic [DW-1:0] w19 [9];
    logic [DW-1:0] wr  [9];
    for (int i = 0; i < 9; i++) w19[i] = DW'(i + 1);

    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // start with no weights loaded is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_noload", 32'(busy), 32'(0));
    tick();

    load_w(w19, 1'b1, 0);
    tick();
    run_frame(0, NPIX, 1'b0, 1'b1);
    wait_idle();
    pattern_literals();

    run_frame(1, NPIX, 1'b0, 1'b1);
    wait_idle();
    pattern_literals();

    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 1) begin
        for (int i = 0; i < 9; i++) wr[i] = DW'($urandom);
        load_w(wr, 1'b0, 30);
        tick();
      end
      run_frame(2, NPIX, 1'b1, 1'b0);
      wait_idle();
      chk("rand_ov_count", 32'(frame_ov), 32'(9));
      repeat ($urandom_range(3)) tick();
    end

    // abandon a frame partway through
    run_frame(0, 12, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_im", 32'(data_im_a | data_im_b | data_im_c), 32'(0));
    chk("midrst_fi", 32'(data_fi_a | data_fi_b | data_fi_c), 32'(0));
    chk("midrst_ctl", 32'({out_valid, pix_ready, busy, done}), 32'(0));
    tick();
    tick();
    reset = 1'b1;
    tick();
    load_w(w19, 1'b0, 0);
    tick();
    run_frame(0, NPIX, 1'b0, 1'b1);
    wait_idle();
    pattern_literals();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
